// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes and select constants for the multicycle MIPS controller.
// S_BNEEX exists only when MC_MAINDEC_BNE_EN is defined.
package mips_ctrl_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_MAINDEC_BNE_EN
    ,S_BNEEX  = 4'd12
`endif
  } state_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
  } ctrl_t;
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state-to-control-word decoder; en_i low forces the whole word to 0.
// Decodes BNEEX only when MC_MAINDEC_BNE_EN is defined.
module mc_ctrl_outdec import mips_ctrl_pkg::*; (
  input  logic [STATE_W-1:0]        state_i,
  input  logic                      mem_ready_i,
  input  logic                      en_i,
  output logic [$bits(ctrl_t)-1:0]  ctrl_o
);
  ctrl_t c;
  always_comb begin
    c = '0;
    if (en_i) begin
      case (state_t'(state_i))
        S_FETCH: begin
          c.alusrcb = SRCB_4;
          c.aluop   = ALUOP_ADD;
          c.pcsrc   = PC_ALU;
          c.irwrite = mem_ready_i;
          c.pcwrite = mem_ready_i;
        end
        S_DECODE: c.alusrcb = SRCB_IMM2;
        S_MEMADR, S_ADDIEX: begin
          c.alusrca = 1'b1;
          c.alusrcb = SRCB_IMM;
        end
        S_MEMRD: c.iord = 1'b1;
        S_MEMWB: begin
          c.memtoreg = 1'b1;
          c.regwrite = 1'b1;
        end
        S_MEMWR: begin
          c.iord     = 1'b1;
          c.memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          c.alusrca = 1'b1;
          c.aluop   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          c.regdst   = 1'b1;
          c.regwrite = 1'b1;
        end
        S_BEQEX: begin
          c.alusrca = 1'b1;
          c.aluop   = ALUOP_SUB;
          c.pcsrc   = PC_ALUOUT;
          c.branch  = 1'b1;
        end
`ifdef MC_MAINDEC_BNE_EN
        S_BNEEX: begin
          c.alusrca   = 1'b1;
          c.aluop     = ALUOP_SUB;
          c.pcsrc     = PC_ALUOUT;
          c.branch_ne = 1'b1;
        end
`endif
        S_ADDIWB: c.regwrite = 1'b1;
        S_JEX: begin
          c.pcsrc   = PC_JUMP;
          c.pcwrite = 1'b1;
        end
        default: c = '0;
      endcase
    end
  end
  assign ctrl_o = c;
endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS main controller FSM with memory-ready stalls.
// Define MC_MAINDEC_BNE_EN to add bne support (BNEEX state, branch_ne output).
module mc_maindec #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       illegal_op
);
  import mips_ctrl_pkg::*;
  logic [STATE_W-1:0] state_q;
  state_t state_d, cur;
  logic illegal_d;
  logic [$bits(ctrl_t)-1:0] ctrl_w;
  ctrl_t ctrl;
  assign cur = state_t'(state_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= STATE_W'(S_FETCH);
    else          state_q <= STATE_W'(state_d);
  end
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (cur)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_MAINDEC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : (op == OP_LW) ? S_MEMRD : S_FETCH;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end
  mc_ctrl_outdec u_outdec (
    .state_i     (cur),
    .mem_ready_i (mem_ready),
    .en_i        (reset_n),
    .ctrl_o      (ctrl_w)
  );
  assign ctrl       = ctrl_t'(ctrl_w);
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign memwrite   = ctrl.memwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign pcsrc      = ctrl.pcsrc;
  assign pcwrite    = ctrl.pcwrite;
  assign branch     = ctrl.branch;
  assign branch_ne  = ctrl.branch_ne;
  assign illegal_op = illegal_d & reset_n;
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: directed cycle-by-cycle check of every output of mc_maindec.
// Expected words: {iord,irwrite,memwrite,regdst,memtoreg,regwrite,alusrca}_alusrcb_aluop_pcsrc_{pcwrite,branch,branch_ne,illegal_op}.
module tb_mc_maindec;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] op = 6'b0;
  logic mem_ready = 1'b1;
  logic iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic pcwrite, branch, branch_ne, illegal_op;
  int errs = 0;
  int checks = 0;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  localparam logic [16:0] E_ZERO = 17'b0000000_00_00_00_0000;
  localparam logic [16:0] E_F1   = 17'b0100000_01_00_00_1000;
  localparam logic [16:0] E_F0   = 17'b0000000_01_00_00_0000;
  localparam logic [16:0] E_DEC  = 17'b0000000_11_00_00_0000;
  localparam logic [16:0] E_ILL  = 17'b0000000_11_00_00_0001;
  localparam logic [16:0] E_MADR = 17'b0000001_10_00_00_0000;
  localparam logic [16:0] E_MRD  = 17'b1000000_00_00_00_0000;
  localparam logic [16:0] E_MWB  = 17'b0000110_00_00_00_0000;
  localparam logic [16:0] E_MWR  = 17'b1010000_00_00_00_0000;
  localparam logic [16:0] E_REX  = 17'b0000001_00_10_00_0000;
  localparam logic [16:0] E_RWB  = 17'b0001010_00_00_00_0000;
  localparam logic [16:0] E_BEQ  = 17'b0000001_00_01_01_0100;
  localparam logic [16:0] E_AEX  = 17'b0000001_10_00_00_0000;
  localparam logic [16:0] E_AWB  = 17'b0000010_00_00_00_0000;
  localparam logic [16:0] E_JEX  = 17'b0000000_00_00_10_1000;
  localparam logic [16:0] E_BNE  = 17'b0000001_00_01_01_0010;
  logic [16:0] outs;
  assign outs = {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, aluop, pcsrc, pcwrite, branch, branch_ne, illegal_op};
  always #5 clk = ~clk;
  mc_maindec #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcwrite(pcwrite), .branch(branch),
    .branch_ne(branch_ne), .illegal_op(illegal_op)
  );
  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (outs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
  endtask
  task automatic step(input logic mr, input logic [5:0] o, input logic [16:0] exp, input string tag);
    mem_ready = mr;
    op = o;
    #1 chk(tag, exp);
    @(posedge clk);
    #2;
  endtask
  initial begin
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("reset_zero", E_ZERO);
    reset_n = 1'b1;
    step(1'b1, LW, E_F1, "lw_fetch");
    step(1'b1, LW, E_DEC, "lw_decode");
    step(1'b1, LW, E_MADR, "lw_memadr");
    step(1'b1, LW, E_MRD, "lw_memrd");
    step(1'b1, LW, E_MWB, "lw_memwb");
    step(1'b1, LW, E_F1, "lw2_fetch");
    step(1'b1, LW, E_DEC, "lw2_decode");
    step(1'b1, LW, E_MADR, "lw2_memadr");
    step(1'b0, LW, E_MRD, "lw2_memrd_wait");
    step(1'b1, LW, E_MRD, "lw2_memrd_done");
    step(1'b1, LW, E_MWB, "lw2_memwb");
    step(1'b1, SW, E_F1, "sw_fetch");
    step(1'b1, SW, E_DEC, "sw_decode");
    step(1'b1, SW, E_MADR, "sw_memadr");
    step(1'b0, SW, E_MWR, "sw_memwr_w1");
    step(1'b0, SW, E_MWR, "sw_memwr_w2");
    step(1'b0, SW, E_MWR, "sw_memwr_w3");
    step(1'b1, SW, E_MWR, "sw_memwr_done");
    step(1'b0, RT, E_F0, "fetch_stall");
    step(1'b1, RT, E_F1, "rt_fetch");
    step(1'b1, RT, E_DEC, "rt_decode");
    step(1'b1, BAD, E_REX, "rt_ex_op_ignored");
    step(1'b1, BAD, E_RWB, "rt_wb");
    step(1'b1, ADDI, E_F1, "addi_fetch");
    step(1'b1, ADDI, E_DEC, "addi_decode");
    step(1'b1, ADDI, E_AEX, "addi_ex");
    step(1'b1, ADDI, E_AWB, "addi_wb");
    step(1'b1, BEQ, E_F1, "beq_fetch");
    step(1'b1, BEQ, E_DEC, "beq_decode");
    step(1'b1, BEQ, E_BEQ, "beq_ex");
    step(1'b1, J, E_F1, "j_fetch");
    step(1'b1, J, E_DEC, "j_decode");
    step(1'b1, J, E_JEX, "j_ex");
    step(1'b1, BAD, E_F1, "bad_fetch");
    step(1'b1, BAD, E_ILL, "bad_illegal");
    step(1'b1, BNE, E_F1, "bne_fetch");
`ifdef MC_MAINDEC_BNE_EN
    step(1'b1, BNE, E_DEC, "bne_decode");
    step(1'b1, BNE, E_BNE, "bne_ex");
`else
    step(1'b1, BNE, E_ILL, "bne_illegal");
`endif
    step(1'b1, SW, E_F1, "rst_sw_fetch");
    step(1'b1, SW, E_DEC, "rst_sw_decode");
    step(1'b1, SW, E_MADR, "rst_sw_memadr");
    mem_ready = 1'b0;
    #1 chk("rst_sw_memwr", E_MWR);
    reset_n = 1'b0;
    #1 chk("rst_async_zero", E_ZERO);
    mem_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_held_zero", E_ZERO);
    reset_n = 1'b1;
    #1 chk("rst_release_fetch", E_F1);
    @(posedge clk);
    #2;
    step(1'b1, LW, E_DEC, "rst_then_decode");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle MIPS main controller FSM.
- Sits directly upstream of the ALU function decoder: produces the 2-bit aluop it consumes, plus all datapath mux selects and write enables.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register (must hold all states, including the optional one).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op  input  6  instruction opcode, valid from the DECODE state onward (IR already loaded).
- mem_ready  input  1  memory completes the current access this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  output  1  instruction register load enable.
- memwrite  output  1  data memory write request.
- regdst  output  1  register write address: 0 = rt, 1 = rd.
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = memory data.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A operand: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B operand: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct field.
- pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcwrite  output  1  unconditional PC write.
- branch  output  1  PC write when ALU zero = 1.
- branch_ne  output  1  PC write when ALU zero = 0.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Moore FSM; outputs decode combinationally from state (and from mem_ready in FETCH only).
- Any output not listed for a state is 0.
- Reset:
  - reset_n low forces state to FETCH asynchronously.
  - While reset_n is low, all outputs are forced to 0, including FETCH's selects.
  - Reset asserted mid-instruction aborts it: no write enable may be high during reset.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Next state by op: lw 100011 or sw 101011 → MEMADR; 000000 → RTYPEEX; beq 000100 → BEQEX; addi 001000 → ADDIEX; j 000010 → JEX.
  - Any other op: illegal_op=1 this cycle, next state FETCH.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1; holds until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
- MEMWR: iord=1, memwrite=1, held high until mem_ready; the cycle with mem_ready=1 is the last cycle; next FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
- JEX: pcsrc=10, pcwrite=1; next FETCH.
- Unreachable state encodings → next state FETCH, all outputs 0.
- Latency with mem_ready always 1: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
- Each mem_ready wait cycle adds one cycle.
- op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.

Optional Feature:
- Macro: MC_MAINDEC_BNE_EN.
- Defined:
  - bne (op 000101) in DECODE → BNEEX.
  - BNEEX outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch_ne=1; next FETCH.
  - Latency 3 cycles.
- Undefined:
  - No BNEEX state; branch_ne tied to 0.
  - op 000101 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (STATE_W bits);
  - opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alusrcb and pcsrc select constants.
- One natural sub-module: mc_ctrl_outdec, a combinational state-to-control-word decoder.
- The FSM register and next-state logic stay in mc_maindec.

Test Plan:
- Reset mid-MEMWR with memwrite=1 → all outputs 0 immediately; after release, state FETCH with alusrcb=01.
- lw (op=100011), mem_ready held 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite high for 4 cycles; FETCH on the following cycle.
- R-type then addi back-to-back → aluop=10 in RTYPEEX; regdst=1 in RTYPEWB; aluop=00 with alusrcb=10 in ADDIEX; regdst=0 in ADDIWB.
- beq and j → branch=1 with pcsrc=01 and aluop=01 in cycle 3; pcwrite=1 with pcsrc=10 in cycle 3.
- op=000101, run with and without MC_MAINDEC_BNE_EN → with macro: branch_ne=1 in BNEEX; without macro: illegal_op=1 in DECODE, back in FETCH next cycle.
